// File: rtl/vdma_wr_frame_sched_pkg.sv
// Shared definitions for the VDMA write-side scheduler and its helpers.
package vdma_wr_frame_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_REQ  = 3'd2,
      ST_XFER = 3'd3,
      ST_LEND = 3'd4,
      ST_FEND = 3'd5
   } sched_state_t;

   localparam int unsigned IDX_W = 2;

   // beat_bytes is a power of two, so synthesis reduces this to a shift
   function automatic logic [63:0] beats_to_bytes(input logic [15:0] beats,
                                                  input int unsigned beat_bytes);
      return 64'(beats) * 64'(beat_bytes);
   endfunction

endpackage

// File: rtl/vdma_wr_frame_sched_buf_rotator.sv
// Next frame-buffer index selection; skips the buffer owned by the reader.
module vdma_buf_rotator
   import vdma_wr_frame_sched_pkg::*;
#(
   parameter int FRAME_NUM = 3
) (
   input  logic [IDX_W-1:0] idx,
   input  logic [IDX_W-1:0] rd_frame_idx,
   output logic [IDX_W-1:0] nxt_idx
);

   logic [IDX_W-1:0] step1;
   logic [IDX_W-1:0] step2;

   always_comb begin
      step1 = (int'(idx) + 1 >= FRAME_NUM) ? '0 : idx + 2'd1;
      step2 = (int'(step1) + 1 >= FRAME_NUM) ? '0 : step1 + 2'd1;
      nxt_idx = step1;
      // with only two buffers there is nowhere else to go, so overwrite
      if (step1 == rd_frame_idx)
         nxt_idx = (FRAME_NUM >= 3) ? step2 : idx;
   end

endmodule

// File: rtl/vdma_wr_frame_sched.sv
// Write-side frame scheduler: cuts each active line into AXI bursts and
// rotates through the frame buffers.
//
// state   | meaning
// IDLE    | waiting for a frame-start pulse
// WAIT    | waiting for enough FIFO beats for the next chunk
// REQ     | burst request raised, waiting for ack
// XFER    | burst accepted, waiting for data phase done
// LEND    | line finished, advance to the next line
// FEND    | frame finished, pulse frame_done and rotate buffer
module vdma_wr_frame_sched
   import vdma_wr_frame_sched_pkg::*;
#(
   parameter int AW         = 32,
   parameter int MAX_BURST  = 256,
   parameter int FRAME_NUM  = 3,
   parameter int BEAT_BYTES = 4
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [AW-1:0]    base_addr,
   input  logic [AW-1:0]    frame_size,
   input  logic [AW-1:0]    line_stride,
   input  logic [15:0]      hactive,
   input  logic [15:0]      vactive,
   input  logic             falign,
   input  logic [15:0]      fifo_count,
   input  logic [1:0]       rd_frame_idx,
   output logic             burst_req,
   output logic [AW-1:0]    burst_addr,
   output logic [8:0]       burst_len,
   input  logic             burst_ack,
   input  logic             burst_done,
   output logic [1:0]       wr_frame_idx,
   output logic             frame_done,
   output logic             sync_err,
   output logic             busy
);

   sched_state_t     state;
   logic [15:0]      line;
   logic [15:0]      beats_left;
   logic [15:0]      hact_r;
   logic [15:0]      vact_r;
   logic [AW-1:0]    line_addr;
   logic [AW-1:0]    cur_addr;
   logic             restart_pend;

   logic [15:0]      chunk;
   logic [1:0]       rot_idx;
   logic [AW-1:0]    start_addr;
   logic [AW-1:0]    rot_start_addr;
   logic             start_ok;

   // idx is at most 3, so the multiply is two gated adds
   function automatic logic [AW-1:0] frame_offset(input logic [1:0] idx,
                                                  input logic [AW-1:0] fs);
      logic [AW-1:0] o;
      o = '0;
      if (idx[0]) o = fs;
      if (idx[1]) o = o + (fs << 1);
      return o;
   endfunction

   vdma_buf_rotator #(.FRAME_NUM(FRAME_NUM)) u_rot (
      .idx          (wr_frame_idx),
      .rd_frame_idx (rd_frame_idx),
      .nxt_idx      (rot_idx)
   );

   always_comb begin
      chunk          = (beats_left > 16'(MAX_BURST)) ? 16'(MAX_BURST) : beats_left;
      start_addr     = base_addr + frame_offset(wr_frame_idx, frame_size);
      rot_start_addr = base_addr + frame_offset(rot_idx, frame_size);
      start_ok       = enable && (hactive != 16'd0) && (vactive != 16'd0);
   end

   task automatic begin_frame(input logic [AW-1:0] addr);
      state      <= ST_WAIT;
      busy       <= 1'b1;
      line       <= '0;
      beats_left <= hactive;
      hact_r     <= hactive;
      vact_r     <= vactive;
      line_addr  <= addr;
      cur_addr   <= addr;
   endtask

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         line         <= '0;
         beats_left   <= '0;
         hact_r       <= '0;
         vact_r       <= '0;
         line_addr    <= '0;
         cur_addr     <= '0;
         restart_pend <= 1'b0;
         burst_req    <= 1'b0;
         burst_addr   <= '0;
         burst_len    <= '0;
         wr_frame_idx <= '0;
         frame_done   <= 1'b0;
         sync_err     <= 1'b0;
         busy         <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (falign && start_ok)
                  begin_frame(start_addr);
            end
            ST_WAIT: begin
               if (falign) begin
                  sync_err <= 1'b1;
                  if (start_ok) begin
                     begin_frame(start_addr);
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end else if (fifo_count >= chunk) begin
                  burst_addr <= cur_addr;
                  burst_len  <= 9'(chunk - 16'd1);
                  burst_req  <= 1'b1;
                  state      <= ST_REQ;
               end
            end
            ST_REQ: begin
               // a raised request is held until accepted, even on resync
               if (falign && !restart_pend) begin
                  restart_pend <= 1'b1;
                  sync_err     <= 1'b1;
               end
               if (burst_ack) begin
                  burst_req <= 1'b0;
                  state     <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (burst_done) begin
                  if (restart_pend || falign) begin
                     restart_pend <= 1'b0;
                     sync_err     <= falign && !restart_pend;
                     if (start_ok) begin
                        begin_frame(start_addr);
                     end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     beats_left <= beats_left - chunk;
                     cur_addr   <= cur_addr + AW'(beats_to_bytes(chunk, BEAT_BYTES));
                     state      <= (beats_left == chunk) ? ST_LEND : ST_WAIT;
                  end
               end else if (falign && !restart_pend) begin
                  restart_pend <= 1'b1;
                  sync_err     <= 1'b1;
               end
            end
            ST_LEND: begin
               if (falign) begin
                  sync_err <= 1'b1;
                  if (start_ok) begin
                     begin_frame(start_addr);
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  line       <= line + 16'd1;
                  line_addr  <= line_addr + line_stride;
                  cur_addr   <= line_addr + line_stride;
                  beats_left <= hact_r;
                  state      <= (line + 16'd1 == vact_r) ? ST_FEND : ST_WAIT;
               end
            end
            ST_FEND: begin
               frame_done   <= 1'b1;
               wr_frame_idx <= rot_idx;
               // a start arriving here opens the next frame on the new buffer
               if (falign && start_ok) begin
                  begin_frame(rot_start_addr);
               end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/vdma_wr_frame_sched.md
Name: vdma_wr_frame_sched

Overview:
Write-side scheduler for the VDMA input path.
- Sits between the native input port and its line FIFO on one side, and the AXI write burst master on the other.
- Watches the frame-start marker and the FIFO fill level, and cuts each active line into bursts of at most MAX_BURST beats.
- Issues burst address/length requests to the master.
- Rotates among FRAME_NUM frame buffers and skips the buffer the read side currently owns.

Parameters:
AW, 32, byte address width
MAX_BURST, 256, maximum beats per burst (power of two, 2..256)
FRAME_NUM, 3, number of frame buffers (2..4)
BEAT_BYTES, 4, bytes per beat (power of two)

Ports:
clock  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  scheduler enable; sampled at frame start
base_addr  in  AW  byte address of buffer 0
frame_size  in  AW  byte spacing between buffers
line_stride  in  AW  byte spacing between lines
hactive  in  16  beats per line
vactive  in  16  lines per frame
falign  in  1  one-cycle frame-start pulse from the input port
fifo_count  in  16  beats currently held in the line FIFO
rd_frame_idx  in  2  buffer index in use by the read side
burst_req  out  1  burst request
burst_addr  out  AW  burst start byte address
burst_len  out  9  burst beats minus 1
burst_ack  in  1  master accepts the request
burst_done  in  1  master finished the data phase of the accepted burst
wr_frame_idx  out  2  buffer currently being written
frame_done  out  1  one-cycle pulse when a frame completes
sync_err  out  1  one-cycle pulse when falign arrives mid-frame
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE. Every output is 0, including wr_frame_idx. Line counter and beat counter are 0.
- All outputs are registered.
- IDLE:
  - Leaves only on falign with enable=1, hactive!=0 and vactive!=0.
  - On leaving: line=0, beats_left=hactive, line_addr = base_addr + wr_frame_idx*frame_size. Next state WAIT.
- WAIT:
  - chunk = min(beats_left, MAX_BURST).
  - When fifo_count >= chunk: load burst_addr=cur_addr, burst_len=chunk-1, assert burst_req the next cycle. Go to REQ.
- REQ:
  - burst_req holds with stable addr/len until the cycle burst_ack=1; it deasserts the following cycle.
  - Go to XFER.
  - Rule: a request is never withdrawn once raised.
- XFER:
  - Waits for burst_done.
  - Then beats_left -= chunk and cur_addr += chunk*BEAT_BYTES.
  - If beats_left reaches 0, go to LEND; otherwise go to WAIT.
- LEND:
  - line += 1; line_addr += line_stride; cur_addr = line_addr; beats_left = hactive.
  - If line == vactive, go to FEND; otherwise go to WAIT.
- FEND:
  - Pulse frame_done and rotate the buffer. Go to IDLE.
  - Rotation: nxt = (idx+1) mod FRAME_NUM.
  - If nxt == rd_frame_idx and FRAME_NUM>=3, use (nxt+1) mod FRAME_NUM.
  - If FRAME_NUM==2 and nxt == rd_frame_idx, keep idx (overwrite).
- Arithmetic: address sums wrap modulo 2^AW. wr_frame_idx*frame_size uses shift/add only (idx<=3).
- falign in WAIT or LEND:
  - Pulse sync_err, do not rotate the buffer, and restart the frame immediately: line=0, same buffer.
  - If enable=0 at that moment, go to IDLE instead.
- falign in REQ or XFER:
  - Latch a restart flag and pulse sync_err once.
  - After burst_done, restart as above.
- falign in FEND: the rotation completes first, then the scheduler restarts on the new buffer in the same cycle it enters IDLE. frame_done and the start are both honoured.
- enable deasserted mid-frame: the current frame continues to FEND. The next falign is ignored.
- hactive/vactive: sampled at frame start. Changes mid-frame take effect next frame.
- Last burst of a line: when hactive % MAX_BURST != 0, the last burst of each line is shorter.
- 4 KB boundary splitting is the AXI master's responsibility.
- Reset mid-burst: all state clears asynchronously. The master is reset by the same rst_n.

Decomposition:
- Shared vdma package: state encoding constants (IDLE, WAIT, REQ, XFER, LEND, FEND) and the helper that converts beats to bytes.
- One natural sub-module, vdma_buf_rotator: combinational next-index selection from idx, rd_frame_idx and FRAME_NUM. Reused by the read-side scheduler.

Test Plan:
1. hactive=640, vactive=2, MAX_BURST=256, base=0x1000_0000, stride=0xA00, BEAT_BYTES=4, fifo_count always 1024 -> 6 bursts: addr 0x1000_0000/len 255, 0x1000_0400/255, 0x1000_0800/127, then 0x1000_0A00/255, 0x1000_0E00/255, 0x1000_1200/127. Then frame_done=1, wr_frame_idx=1.
2. Three frames with FRAME_NUM=3, rd_frame_idx=2 -> wr_frame_idx goes 0, 1, 0 (2 skipped).
3. FRAME_NUM=2, rd_frame_idx=1 -> wr_frame_idx stays 0 and frame_done still pulses.
4. fifo_count held at 100 with chunk=256 -> burst_req stays 0. Raise fifo_count to 256 -> burst_req=1 next cycle. Delay burst_ack 5 cycles -> addr/len stable throughout, req drops the cycle after ack.
5. falign during XFER on line 1 -> sync_err pulses once. After burst_done, the next request is at the buffer-0 line-0 address and frame_done is not pulsed.
6. Assert rst_n=0 during REQ -> burst_req, busy and wr_frame_idx go to 0 immediately. After release, the scheduler waits in IDLE for falign.
